// File: rtl/xbar_pkg.sv
// Crossbar packet layout shared by PE send logic, crossbar ports and arbiters.
// Also holds the arbiter state encoding.
`ifndef XBAR_PKG_MACROS
`define XBAR_PKG_MACROS
`define XBAR_PACKET(w) logic [(w)-1:0]
`define XBAR_PAYLOAD(pkt) (pkt)[31:0]
`endif

package xbar_pkg;

    localparam int XBAR_P_W     = 64;
    localparam int XBAR_VLD_BIT = 63;
    localparam int XBAR_DST_LSB = 32;
    localparam int XBAR_DST_W   = 4;

    // EMPTY: output register free; FULL: out_packet waits for downstream.
    typedef enum logic {
        ARB_EMPTY = 1'b0,
        ARB_FULL  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/xbar_out_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at N-1.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    always_comb begin
        logic found;
        int   j;
        found  = 1'b0;
        winner = '0;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j]) begin
                found  = 1'b1;
                winner = IDX_W'(j);
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/xbar_out_arb.sv
// Round-robin arbiter and output register for one crossbar output port.
// Optional statistics counters are built when XBAR_ARB_STATS_EN is defined.
module xbar_out_arb
    import xbar_pkg::*;
#(
    parameter int N       = 4,
    parameter int P_W     = XBAR_P_W,
    parameter int VLD_BIT = XBAR_VLD_BIT,
    parameter int DST_LSB = XBAR_DST_LSB,
    parameter int DST_W   = XBAR_DST_W,
    parameter int PORT_ID = 0,
    parameter int IDX_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*P_W-1:0]   in_packet,
    output logic [N-1:0]       in_ack,
    output logic [P_W-1:0]     out_packet,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [IDX_W-1:0]   grant_idx
`ifdef XBAR_ARB_STATS_EN
    ,
    output logic [N*32-1:0]    stat_grants,
    output logic [31:0]        stat_stall
`endif
);

    // Handshake: in_ack[i] high means PE i's packet is taken at the coming edge;
    // out_packet is consumed at any edge where out_vld && out_rdy.

    arb_state_e        state;
    arb_state_e        state_nxt;
    logic [N-1:0]      req;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  winner;
    logic              any_req;
    logic              can_load;
    logic              grant;
    `XBAR_PACKET(P_W)  win_packet;

    always_comb begin
        req = '0;
        for (int i = 0; i < N; i++) begin
            req[i] = in_packet[i*P_W + VLD_BIT] &&
                     (in_packet[i*P_W + DST_LSB +: DST_W] == DST_W'(PORT_ID));
        end
    end

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req     (req),
        .ptr     (ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    assign can_load   = (state == ARB_EMPTY) || out_rdy;
    // Reset gates the grant so no ack escapes while rst is low.
    assign grant      = rst && can_load && any_req;
    assign win_packet = in_packet[int'(winner)*P_W +: P_W];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ARB_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_EMPTY: if (grant) state_nxt = ARB_FULL;
            ARB_FULL:  if (out_rdy && !grant) state_nxt = ARB_EMPTY;
            default:   state_nxt = ARB_EMPTY;
        endcase
    end

    always_comb begin
        out_vld = (state == ARB_FULL);
        in_ack  = '0;
        if (grant) begin
            in_ack[winner] = 1'b1;
        end
    end

    // Pointer wraps by explicit compare so non-power-of-two N stays in range.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_packet <= '0;
            grant_idx  <= '0;
            ptr        <= '0;
        end else if (grant) begin
            out_packet <= win_packet;
            grant_idx  <= winner;
            ptr        <= (winner == IDX_W'(N-1)) ? '0 : winner + 1'b1;
        end
    end

`ifdef XBAR_ARB_STATS_EN
    localparam logic [31:0] STAT_MAX = '1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_grants <= '0;
            stat_stall  <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (in_ack[i] && (stat_grants[i*32 +: 32] != STAT_MAX)) begin
                    stat_grants[i*32 +: 32] <= stat_grants[i*32 +: 32] + 32'd1;
                end
            end
            if (out_vld && !out_rdy && any_req && (stat_stall != STAT_MAX)) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_xbar_out_arb.sv
// Self-checking bench for xbar_out_arb (N=4, PORT_ID=0); stats checks build with XBAR_ARB_STATS_EN.
module tb_xbar_out_arb;

    localparam int N     = 4;
    localparam int P_W   = 64;
    localparam int IDX_W = 2;

    logic             clk;
    logic             rst;
    logic [N*P_W-1:0] in_packet;
    logic [N-1:0]     in_ack;
    logic [P_W-1:0]   out_packet;
    logic             out_vld;
    logic             out_rdy;
    logic [IDX_W-1:0] grant_idx;
`ifdef XBAR_ARB_STATS_EN
    logic [N*32-1:0]  stat_grants;
    logic [31:0]      stat_stall;
`endif

    logic [P_W-1:0]   pk [N];
    logic [P_W-1:0]   exp_q [$];
    logic [IDX_W-1:0] idx_q [$];
    int               checks;
    int               errors;

    xbar_out_arb #(
        .N (N), .P_W (P_W), .VLD_BIT (63), .DST_LSB (32), .DST_W (4),
        .PORT_ID (0), .IDX_W (IDX_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_packet  (in_packet),
        .in_ack     (in_ack),
        .out_packet (out_packet),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .grant_idx  (grant_idx)
`ifdef XBAR_ARB_STATS_EN
        ,
        .stat_grants (stat_grants),
        .stat_stall  (stat_stall)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            in_packet[i*P_W +: P_W] = pk[i];
        end
    end

    function automatic logic [P_W-1:0] mk(input logic v, input logic [3:0] d, input logic [31:0] pay);
        return {v, 27'd0, d, pay};
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Check the combinational ack and queue the packet it should capture.
    task automatic expect_ack(input string tag, input logic [N-1:0] exp);
        #1;
        check(tag, {60'd0, in_ack}, {60'd0, exp});
        for (int i = 0; i < N; i++) begin
            if (exp[i]) begin
                exp_q.push_back(pk[i]);
                idx_q.push_back(IDX_W'(i));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            check("cap_vld", {63'd0, out_vld}, 64'd1);
            check("cap_packet", out_packet, exp_q.pop_front());
            check("cap_idx", {62'd0, grant_idx}, {62'd0, idx_q.pop_front()});
        end
    endtask

    initial begin
        logic [P_W-1:0]   held;
        logic [P_W-1:0]   last_pkt;
        logic [N-1:0]     exp_ack;
        logic [IDX_W-1:0] m_ptr;
        logic             m_vld;
        logic             can;
        logic             found;
        int               w;
        int               j;

        checks  = 0;
        errors  = 0;
        rst     = 1'b0;
        out_rdy = 1'b1;
        for (int i = 0; i < N; i++) pk[i] = '0;
        pk[1] = mk(1'b1, 4'd0, 32'hdead_0001);
        tick();
        tick();
        check("rst_ack_forced", {60'd0, in_ack}, 64'd0);
        check("rst_vld", {63'd0, out_vld}, 64'd0);
        check("rst_packet", out_packet, 64'd0);
        check("rst_idx", {62'd0, grant_idx}, 64'd0);

        // single requester
        rst   = 1'b1;
        pk[1] = '0;
        pk[2] = mk(1'b1, 4'd0, 32'haaaa_0002);
        expect_ack("single_ack", 4'b0100);
        tick();
        pk[2] = '0;
        expect_ack("idle_ack", 4'b0000);
        tick();
        check("drain_vld", {63'd0, out_vld}, 64'd0);

        // destination filter
        pk[0] = mk(1'b1, 4'd1, 32'hbbbb_0000);
        expect_ack("filter_ack", 4'b0000);
        tick();
        check("filter_vld", {63'd0, out_vld}, 64'd0);
        pk[0] = '0;

        // backpressure (ptr is 3 after the single grant)
        pk[1] = mk(1'b1, 4'd0, 32'hcccc_0001);
        pk[3] = mk(1'b1, 4'd0, 32'hcccc_0003);
        held  = pk[3];
        expect_ack("bp_first", 4'b1000);
        tick();
        out_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            expect_ack("bp_stall_ack", 4'b0000);
            tick();
            check("bp_hold_packet", out_packet, held);
            check("bp_hold_vld", {63'd0, out_vld}, 64'd1);
        end
        out_rdy = 1'b1;
        expect_ack("bp_release", 4'b0010);
        tick();

        // reset while holding a packet
        out_rdy = 1'b0;
        expect_ack("hold_ack", 4'b0000);
        rst = 1'b0;
        expect_ack("midrst_ack", 4'b0000);
        tick();
        check("midrst_vld", {63'd0, out_vld}, 64'd0);
        check("midrst_idx", {62'd0, grant_idx}, 64'd0);
        check("midrst_packet", out_packet, 64'd0);

        // full contention from ptr 0
        rst     = 1'b1;
        out_rdy = 1'b1;
        for (int i = 0; i < N; i++) pk[i] = mk(1'b1, 4'd0, 32'h100 + i);
        for (int k = 0; k < 5; k++) begin
            exp_ack = '0;
            exp_ack[k % N] = 1'b1;
            expect_ack("contend_ack", exp_ack);
            tick();
        end

        // random traffic against a reference model
        m_ptr    = 2'd1;
        m_vld    = 1'b1;
        last_pkt = pk[0];
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < N; i++) begin
                pk[i] = mk($urandom_range(0, 3) != 0, 4'($urandom_range(0, 1)), $urandom);
            end
            out_rdy = 1'($urandom_range(0, 1));
            exp_ack = '0;
            can     = !m_vld || out_rdy;
            found   = 1'b0;
            w       = 0;
            for (int k = 0; k < N; k++) begin
                j = (int'(m_ptr) + k) % N;
                if (can && !found && pk[j][63] && (pk[j][35:32] == 4'd0)) begin
                    found = 1'b1;
                    w     = j;
                end
            end
            if (found) exp_ack[w] = 1'b1;
            expect_ack("rand_ack", exp_ack);
            if (found) last_pkt = pk[w];
            tick();
            if (found) begin
                m_vld = 1'b1;
                m_ptr = IDX_W'((w + 1) % N);
            end else if (can) begin
                m_vld = 1'b0;
            end
            check("rand_vld", {63'd0, out_vld}, {63'd0, m_vld});
            if (m_vld && !found) check("rand_hold", out_packet, last_pkt);
        end

`ifdef XBAR_ARB_STATS_EN
        rst = 1'b0;
        tick();
        tick();
        check("stat_clear", {32'd0, stat_stall}, 64'd0);
        rst     = 1'b1;
        out_rdy = 1'b1;
        for (int i = 0; i < N; i++) pk[i] = (i < 3) ? mk(1'b1, 4'd0, 32'h200 + i) : '0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
        end
        #1;
        check("stat_g0", {32'd0, stat_grants[0 +: 32]}, 64'd34);
        check("stat_g1", {32'd0, stat_grants[32 +: 32]}, 64'd33);
        check("stat_g2", {32'd0, stat_grants[64 +: 32]}, 64'd33);
        check("stat_g3", {32'd0, stat_grants[96 +: 32]}, 64'd0);
        check("stat_stall", {32'd0, stat_stall}, 64'd0);
        for (int i = 0; i < N; i++) pk[i] = '0;
`endif

        if (exp_q.size() != 0) begin
            check("queue_drained", 64'(exp_q.size()), 64'd0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
